// File: rtl/fir_param_filter.sv
// Parametrised direct-form FIR with a valid/ready sample path and a counted serial coefficient load.
// Optional FIR_PARAM_SAT_EN: saturate the narrowed output instead of two's-complement wrapping.
module fir_param_filter #(
    parameter int DATA_W    = 6,
    parameter int COEF_W    = 2,
    parameter int TAPS      = 8,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     cfg_start,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     coef_valid,
    output logic                     cfg_done,
    output logic                     busy_cfg,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid
);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int WIDE_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam int CNT_W  = $clog2(TAPS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_LOAD = 2'd2} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [DATA_W-1:0]  buff_q [TAPS];
    logic signed [DATA_W-1:0]  buff_d [TAPS];
    logic signed [OUT_W-1:0]   out_data_q;
    logic                      out_valid_q;
    logic                      cfg_done_q;
    logic                      in_ready_q;
    logic                      busy_cfg_q;
    logic                      accept_s;
    logic signed [ACC_W-1:0]   acc_s;
    logic signed [ACC_W-1:0]   shifted_s;

    function automatic logic signed [OUT_W-1:0] narrow_f(input logic signed [ACC_W-1:0] v);
        logic signed [WIDE_W-1:0] w;
`ifdef FIR_PARAM_SAT_EN
        logic signed [WIDE_W-1:0] max_w;
        logic signed [WIDE_W-1:0] min_w;
        w     = WIDE_W'(v);
        max_w = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        min_w = ~max_w;
        if (w > max_w) begin
            w = max_w;
        end else if (w < min_w) begin
            w = min_w;
        end else begin
            w = w;
        end
`else
        w = WIDE_W'(v);
`endif
        return w[OUT_W-1:0];
    endfunction

    // Accept decision, next delay line and the tap sum over the post-shift line.
    always_comb begin
        accept_s = in_valid && in_ready_q && !cfg_start;
        buff_d   = buff_q;
        if (accept_s) begin
            buff_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                buff_d[k] = buff_q[k-1];
            end
        end else begin
            buff_d = buff_q;
        end
        acc_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_s = acc_s + ACC_W'(coef_q[k]) * ACC_W'(buff_d[k]);
        end
        shifted_s = acc_s >>> OUT_SHIFT;
    end

    // Control FSM, coefficient shift register, delay line and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_cfg_q  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                buff_q[k] <= '0;
                coef_q[k] <= (k % 2 == 0) ? {{(COEF_W-1){1'b0}}, 1'b1} : '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            buff_q      <= buff_d;
            if (accept_s) begin
                out_data_q  <= narrow_f(shifted_s);
                out_valid_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_RUN: begin
                    in_ready_q <= 1'b1;
                    busy_cfg_q <= 1'b0;
                    if (cfg_start) begin
                        state_q    <= S_LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_cfg_q <= 1'b1;
                    end else if (accept_s) begin
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    in_ready_q <= 1'b0;
                    busy_cfg_q <= 1'b1;
                    if (cfg_start) begin
                        cnt_q <= '0;
                    end else if (coef_valid) begin
                        coef_q[0] <= coef_in;
                        for (int k = 1; k < TAPS; k++) begin
                            coef_q[k] <= coef_q[k-1];
                        end
                        if (cnt_q == CNT_W'(TAPS - 1)) begin
                            // Fresh coefficients start from an empty history.
                            for (int k = 0; k < TAPS; k++) begin
                                buff_q[k] <= '0;
                            end
                            cnt_q      <= '0;
                            cfg_done_q <= 1'b1;
                            state_q    <= S_IDLE;
                            in_ready_q <= 1'b1;
                            busy_cfg_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_cfg_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy_cfg  = busy_cfg_q;
    assign cfg_done  = cfg_done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
endmodule
